// File: rtl/secuenciador_cs.sv
// secuenciador_cs: control sequencer for the Von Neumann processor.
// It fetches instructions over a ready-handshaked memory port, decodes them and
// steps each one through a Moore FSM. The FSM produces the 5-bit cs control word
// and the 4-bit operacion for the tri-state bus driver downstream.
// cs = 5'b11000 is raised for exactly one cycle per executable instruction.
//
// Ports:
//   clk        in   1     system clock, rising edge
//   rst        in   1     asynchronous reset, active-high
//   start      in   1     run request, sampled in IDLE/HALT only
//   instr      in   8     memory data: [7:4] opcode, [3:0] operand
//   mem_ready  in   1     memory has a valid instr this cycle
//   mem_rd     out  1     memory read request, high in FETCH
//   pc         out  PC_W  current instruction address
//   cs         out  5     control word to bus driver / datapath
//   operacion  out  4     operation code presented to bus driver
//   busy       out  1     high in FETCH, DECODE, DRIVE, WB
//   halted     out  1     high in HALT
//   err        out  1     high in ERROR (sticky until rst)
//
// Every output is a register loaded from the next-state value. The outputs
// therefore always match the current state, and no input reaches an output
// combinationally.
module secuenciador_cs #(
  parameter int unsigned        PC_W         = 4,
  parameter logic [PC_W-1:0]    RESET_PC     = '0,
  parameter int unsigned        MEM_WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      instr,
  input  logic            mem_ready,
  output logic            mem_rd,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      cs,
  output logic [3:0]      operacion,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  localparam int unsigned WAIT_W   = 8;
  localparam int unsigned CS_W     = 5;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned INSTR_W  = 8;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
  localparam logic [OP_W-1:0]   OPC_NOP   = 4'h0;
  localparam logic [OP_W-1:0]   OPC_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DRIVE,
    S_WB,
    S_HALT,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [WAIT_W-1:0]   waitcnt_q, waitcnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [CS_W-1:0]     cs_q, cs_d;
  logic                mem_rd_q, busy_q, halted_q, err_q;
  logic                mem_rd_d, busy_d, halted_d, err_d;

  // Control word encoding for each state.
  function automatic logic [CS_W-1:0] cs_of(input state_e s);
    case (s)
      S_FETCH:  cs_of = 5'b10001;
      S_DECODE: cs_of = 5'b10010;
      S_DRIVE:  cs_of = 5'b11000;
      S_WB:     cs_of = 5'b10100;
      S_HALT:   cs_of = 5'b01111;
      S_ERROR:  cs_of = 5'b01110;
      default:  cs_of = 5'b00000;
    endcase
  endfunction

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    waitcnt_d = '0;
    op_d      = op_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // A ready in the last allowed cycle still counts as success.
        if (mem_ready) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (waitcnt_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          waitcnt_d = waitcnt_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (ir_q[7:4] == OPC_HALT) begin
          state_d = S_HALT;
        end else if (ir_q[7:4] == OPC_NOP) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else begin
          op_d    = ir_q[7:4];
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: state_d = S_WB;
      S_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    cs_d     = cs_of(state_d);
    mem_rd_d = (state_d == S_FETCH);
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_DRIVE) || (state_d == S_WB);
    halted_d = (state_d == S_HALT);
    err_d    = (state_d == S_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      waitcnt_q <= '0;
      op_q      <= '0;
      cs_q      <= '0;
      mem_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      waitcnt_q <= waitcnt_d;
      op_q      <= op_d;
      cs_q      <= cs_d;
      mem_rd_q  <= mem_rd_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign pc        = pc_q;
  assign cs        = cs_q;
  assign operacion = op_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_secuenciador_cs.sv
// Directed testbench for secuenciador_cs. Instruction memory is a small array
// indexed by the DUT pc; all expected values are hand-computed constants.
module tb_secuenciador_cs;

  localparam int unsigned PC_W = 4;

  localparam logic [4:0] CS_IDLE   = 5'b00000;
  localparam logic [4:0] CS_FETCH  = 5'b10001;
  localparam logic [4:0] CS_DECODE = 5'b10010;
  localparam logic [4:0] CS_DRIVE  = 5'b11000;
  localparam logic [4:0] CS_WB     = 5'b10100;
  localparam logic [4:0] CS_HALT   = 5'b01111;
  localparam logic [4:0] CS_ERROR  = 5'b01110;

  logic            clk;
  logic            rst;
  logic            start;
  logic [7:0]      instr;
  logic            mem_ready;
  logic            mem_rd;
  logic [PC_W-1:0] pc;
  logic [4:0]      cs;
  logic [3:0]      operacion;
  logic            busy;
  logic            halted;
  logic            err;

  logic [7:0] prog [16];

  int errors;
  int checks;

  secuenciador_cs #(
    .PC_W(PC_W),
    .RESET_PC(4'd0),
    .MEM_WAIT_MAX(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .instr(instr),
    .mem_ready(mem_ready),
    .mem_rd(mem_rd),
    .pc(pc),
    .cs(cs),
    .operacion(operacion),
    .busy(busy),
    .halted(halted),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the word at the current pc.
  always_comb instr = prog[pc];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [4:0] exp_cs,
                           input logic exp_rd, input logic exp_busy,
                           input logic exp_halt, input logic exp_err);
    chk(tag, {24'd0, cs, mem_rd, busy, halted, err},
        {24'd0, exp_cs, exp_rd, exp_busy, exp_halt, exp_err});
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h35;

    tick();
    tick();
    chk_flags("reset_flags", CS_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_op", 32'(operacion), 32'd0);

    // Basic 4-cycle instruction 0x35.
    rst = 1'b0;
    tick();
    chk_flags("idle_no_start", CS_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    start     = 1'b1;
    mem_ready = 1'b1;
    tick();
    start = 1'b0;
    chk_flags("i35_fetch", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("i35_decode", CS_DECODE, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("i35_drive", CS_DRIVE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("i35_op", 32'(operacion), 32'h3);
    tick();
    chk_flags("i35_wb", CS_WB, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("i35_pc_wb", 32'(pc), 32'd0);
    chk("i35_op_hold", 32'(operacion), 32'h3);
    tick();
    chk_flags("i35_fetch2", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("i35_pc_next", 32'(pc), 32'd1);

    // Async reset in the middle of DRIVE.
    tick();
    tick();
    chk_flags("pre_rst_drive", CS_DRIVE, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_flags("async_rst_flags", CS_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async_rst_pc", 32'(pc), 32'd0);
    chk("async_rst_op", 32'(operacion), 32'd0);
    tick();
    rst = 1'b0;

    // Program NOP, 0x27, HALT.
    prog[0] = 8'h00;
    prog[1] = 8'h27;
    prog[2] = 8'hF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_flags("p_fetch0", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("p_nop_decode", CS_DECODE, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("p_fetch1", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("p_pc1", 32'(pc), 32'd1);
    chk("p_op_untouched", 32'(operacion), 32'd0);
    tick();
    tick();
    chk_flags("p_drive", CS_DRIVE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p_op2", 32'(operacion), 32'h2);
    tick();
    chk_flags("p_wb", CS_WB, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("p_pc2", 32'(pc), 32'd2);
    tick();
    chk_flags("p_halt_decode", CS_DECODE, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("p_halt", CS_HALT, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p_halt_pc", 32'(pc), 32'd2);
    tick();
    chk_flags("p_halt_stay", CS_HALT, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p_halt_pc_frozen", 32'(pc), 32'd2);
    chk("p_halt_op_hold", 32'(operacion), 32'h2);

    // Restart from HALT, then starve memory into ERROR.
    start     = 1'b1;
    mem_ready = 1'b0;
    tick();
    start = 1'b0;
    chk_flags("restart_fetch", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_pc", 32'(pc), 32'd0);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk_flags($sformatf("starve_fetch_%0d", i), CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_flags("timeout_error", CS_ERROR, 1'b0, 1'b0, 1'b0, 1'b1);
    start     = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    chk_flags("error_sticky", CS_ERROR, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    chk_flags("error_rst_clear", CS_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    // Ready arrives on the 15th FETCH cycle: no ERROR.
    mem_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 15; i++) tick();
    chk_flags("late_fetch15", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick();
    chk_flags("late_decode", CS_DECODE, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_flags("late_nop_fetch", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("late_pc1", 32'(pc), 32'd1);

    // PC wrap: NOPs at 0..14, 0x51 at 15.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) prog[i] = 8'h00;
    prog[15] = 8'h51;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("wrap_pc_%0d", i), 32'(pc), 32'(i));
      tick();
      tick();
    end
    chk_flags("wrap_fetch15", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_pc15", 32'(pc), 32'd15);
    tick();
    tick();
    chk_flags("wrap_drive", CS_DRIVE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_op5", 32'(operacion), 32'h5);
    tick();
    chk("wrap_wb_pc", 32'(pc), 32'd15);
    tick();
    chk_flags("wrap_fetch0", CS_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_pc0", 32'(pc), 32'd0);
    tick();
    tick();
    chk("wrap_continue_pc1", 32'(pc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
